// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: bus widths, field offsets
// of the EX->MEM bus, load-op encodings and the response-buffer states.
// No ports (package).
package mem_stage_pkg;

  localparam int ES_BUS_W  = 75;
  localparam int MS_BUS_W  = 70;
  localparam int FWD_BUS_W = 39;

  // es_to_ms_bus field offsets
  localparam int ES_PC_LSB      = 0;
  localparam int ES_ALU_LSB     = 32;
  localparam int ES_DEST_LSB    = 64;
  localparam int ES_GRWE_BIT    = 69;
  localparam int ES_RFM_BIT     = 70;
  localparam int ES_LOADOP_LSB  = 71;
  localparam int ES_MEMREQ_BIT  = 74;

  // ms_to_ws_bus field offsets
  localparam int MS_RES_LSB  = 0;
  localparam int MS_DEST_LSB = 32;
  localparam int MS_GRWE_BIT = 37;
  localparam int MS_PC_LSB   = 38;

  // ms_to_ds_bus field offsets
  localparam int FWD_RES_LSB   = 0;
  localparam int FWD_DEST_LSB  = 32;
  localparam int FWD_WAIT_BIT  = 37;
  localparam int FWD_WE_BIT    = 38;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_op_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Field order matches es_to_ms_bus, MSB first.
  typedef struct packed {
    logic        mem_req;
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align
// Combinational load-data extraction: picks the addressed byte/half of the
// raw read word and sign/zero-extends it. Unknown load ops return the word.
// Ports:
//   raw_i       32  raw read word
//   off_i       2   byte offset (address[1:0])
//   load_op_i   3   load op encoding (load_op_e)
//   load_data_o 32  extracted, extended data
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  load_op_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(raw_i >> {off_i, 3'b000});
    half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (load_op_i)
      LOAD_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data_o = {24'h0, byte_sel};
      LOAD_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data_o = {16'h0, half_sel};
      default:  load_data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// MEM pipeline stage between EX and WB. Holds the instruction until the
// data-SRAM response for its memory request arrives, buffering the response
// if WB is stalled, then forwards {pc, gr_we, dest, final_result} to WB.
// Also drives the forwarding/stall bus towards ID.
// Ports:
//   clk, resetn          clock, async active-low reset
//   es_to_ms_valid/_bus  instruction from EX
//   ms_allowin           MEM can accept from EX
//   ws_allowin           WB can accept
//   ms_to_ws_valid/_bus  result to WB
//   ms_to_ds_bus         {fwd_we, load_wait, dest, result} to ID
//   data_sram_data_ok    response pulse for oldest outstanding request
//   data_sram_rdata      read data, valid with data_ok
//
// Response buffer states:
//   state     | meaning
//   BUF_EMPTY | no captured response; read data comes straight from SRAM
//   BUF_FULL  | response captured while WB stalled; held until MEM drains
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MS_BUS_W-1:0]  ms_to_ws_bus,
  output logic [FWD_BUS_W-1:0] ms_to_ds_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata
);

  logic       ms_valid_q, ms_valid_d;
  es_bus_t    es_q, es_d;
  buf_state_e buf_q, buf_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        buf_valid;
  logic        ms_ready_go;
  logic        load_wait;
  logic [31:0] raw_data;
  logic [31:0] load_data;
  logic [31:0] final_result;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      es_q       <= '0;
      buf_q      <= BUF_EMPTY;
      buf_data_q <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      es_q       <= es_d;
      buf_q      <= buf_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign buf_valid      = (buf_q == BUF_FULL);
  assign ms_ready_go    = !es_q.mem_req || buf_valid || data_sram_data_ok;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  always_comb begin
    ms_valid_d = ms_valid_q;
    es_d       = es_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      es_d       = es_to_ms_bus;
    end
  end

  // Capture only a response that belongs to the instruction in MEM and
  // cannot leave this cycle; anything else (stale/orphan data_ok) is dropped.
  always_comb begin
    buf_d      = buf_q;
    buf_data_d = buf_data_q;
    case (buf_q)
      BUF_EMPTY: begin
        if (ms_valid_q && es_q.mem_req && data_sram_data_ok && !ws_allowin) begin
          buf_d      = BUF_FULL;
          buf_data_d = data_sram_rdata;
        end
      end
      BUF_FULL: begin
        if (ms_to_ws_valid && ws_allowin) begin
          buf_d = BUF_EMPTY;
        end
      end
      default: buf_d = BUF_EMPTY;
    endcase
  end

  assign raw_data = buf_valid ? buf_data_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .raw_i       (raw_data),
    .off_i       (es_q.alu_result[1:0]),
    .load_op_i   (es_q.load_op),
    .load_data_o (load_data)
  );

  assign final_result = es_q.res_from_mem ? load_data : es_q.alu_result;
  assign load_wait    = ms_valid_q && es_q.res_from_mem && !ms_ready_go;

  assign ms_to_ws_bus = {es_q.pc, es_q.gr_we, es_q.dest, final_result};
  assign ms_to_ds_bus = {ms_valid_q && es_q.gr_we, load_wait, es_q.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int passed = 0;
  logic [69:0] sb[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] mk(logic mr, logic [2:0] op, logic rfm, logic we,
                                     logic [4:0] d, logic [31:0] alu, logic [31:0] pc);
    return {mr, op, rfm, we, d, alu, pc};
  endfunction

  task automatic chk(string tag, logic [69:0] obs, logic [69:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: at the negedge, pop/compare any transfer to WB; return at posedge+1.
  task automatic cycle();
    logic [69:0] e;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        checks++;
        $error("FAIL sb_underflow observed=%h expected=none", ms_to_ws_bus);
      end else begin
        e = sb.pop_front();
        chk("ms_to_ws_bus", ms_to_ws_bus, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [74:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    #1;
    chk("send_allowin", 70'(ms_allowin), 70'd1);
    @(posedge clk);
    #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic load_case(logic [2:0] op, logic [1:0] off, logic [31:0] exp);
    logic [31:0] pc;
    pc = pc_ctr;
    pc_ctr += 4;
    send(mk(1'b1, op, 1'b1, 1'b1, 5'd7, 32'h0000_2000 | 32'(off), pc));
    chk("ld_wait_pre", 70'(ms_to_ds_bus[37]), 70'd1);
    chk("ld_valid_pre", 70'(ms_to_ws_valid), 70'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0011;
    #1;
    chk("ld_result", 70'(ms_to_ds_bus[31:0]), 70'(exp));
    chk("ld_wait_post", 70'(ms_to_ds_bus[37]), 70'd0);
    sb.push_back({pc, 1'b1, 5'd7, exp});
    cycle();
    data_sram_data_ok = 1'b0;
  endtask

  logic [2:0]  t_op  [10] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd1, 3'd0, 3'd7, 3'd2, 3'd1};
  logic [1:0]  t_off [10] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
  logic [31:0] t_exp [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF,
                              32'h0000_0011, 32'h0000_0000, 32'h80FF_0011, 32'h80FF_0011,
                              32'h0000_00FF, 32'hFFFF_FFFF};

  initial begin
    logic [31:0] pc;
    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_allowin", 70'(ms_allowin), 70'd1);
    chk("rst_ds_bus", 70'(ms_to_ds_bus), 70'd0);
    chk("rst_ws_bus", ms_to_ws_bus, 70'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // ALU op passes in one cycle
    pc = pc_ctr; pc_ctr += 4;
    send(mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, pc));
    chk("alu_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("alu_fwd", 70'(ms_to_ds_bus), 70'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
    sb.push_back({pc, 1'b1, 5'd5, 32'h1234_5678});
    cycle();

    // Load extraction, data_ok same cycle
    for (int i = 0; i < 10; i++) load_case(t_op[i], t_off[i], t_exp[i]);

    // LW with data_ok delayed 3 cycles
    pc = pc_ctr; pc_ctr += 4;
    send(mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, pc));
    for (int i = 0; i < 3; i++) begin
      chk("dly_valid", 70'(ms_to_ws_valid), 70'd0);
      chk("dly_allowin", 70'(ms_allowin), 70'd0);
      chk("dly_wait", 70'(ms_to_ds_bus[37]), 70'd1);
      cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("dly_wait_done", 70'(ms_to_ds_bus[37]), 70'd0);
    sb.push_back({pc, 1'b1, 5'd9, 32'hCAFE_F00D});
    cycle();
    data_sram_data_ok = 1'b0;

    // Response buffered while WB stalls; new load accepted on the leaving edge
    ws_allowin = 1'b0;
    pc = pc_ctr; pc_ctr += 4;
    send(mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd10, 32'h0000_4000, pc));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("buf_allowin_stall", 70'(ms_allowin), 70'd0);
    cycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("buf_valid_hold", 70'(ms_to_ws_valid), 70'd1);
      chk("buf_result_hold", 70'(ms_to_ds_bus[31:0]), 70'(32'hDEAD_BEEF));
      cycle();
    end
    ws_allowin = 1'b1;
    sb.push_back({pc, 1'b1, 5'd10, 32'hDEAD_BEEF});
    pc = pc_ctr; pc_ctr += 4;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd11, 32'h0000_5000, pc);
    #1;
    chk("buf_leave_allowin", 70'(ms_allowin), 70'd1);
    cycle();
    es_to_ms_valid = 1'b0;
    chk("buf_cleared_wait", 70'(ms_to_ds_bus[37]), 70'd1);
    chk("buf_cleared_valid", 70'(ms_to_ws_valid), 70'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_F00D;
    sb.push_back({pc, 1'b1, 5'd11, 32'h0BAD_F00D});
    cycle();
    data_sram_data_ok = 1'b0;

    // Store waits for data_ok, rdata discarded
    pc = pc_ctr; pc_ctr += 4;
    send(mk(1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0000_6004, pc));
    chk("st_valid_pre", 70'(ms_to_ws_valid), 70'd0);
    chk("st_wait", 70'(ms_to_ds_bus[37]), 70'd0);
    cycle();
    chk("st_valid_hold", 70'(ms_to_ws_valid), 70'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_AAAA;
    #1;
    chk("st_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("st_fwd_we", 70'(ms_to_ds_bus[38]), 70'd0);
    sb.push_back({pc, 1'b0, 5'd0, 32'h0000_6004});
    cycle();
    data_sram_data_ok = 1'b0;

    // Back-to-back ALU ops
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd12, 32'h0000_00AA, pc_ctr);
    sb.push_back({pc_ctr, 1'b1, 5'd12, 32'h0000_00AA});
    pc_ctr += 4;
    cycle();
    es_to_ms_bus = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd13, 32'h0000_00BB, pc_ctr);
    sb.push_back({pc_ctr, 1'b1, 5'd13, 32'h0000_00BB});
    pc_ctr += 4;
    cycle();
    es_to_ms_valid = 1'b0;
    cycle();
    chk("b2b_idle", 70'(ms_to_ws_valid), 70'd0);

    // Reset during a load wait, then orphan data_ok
    send(mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd14, 32'h0000_7000, pc_ctr));
    pc_ctr += 4;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("mid_rst_allowin", 70'(ms_allowin), 70'd1);
    chk("mid_rst_ds", 70'(ms_to_ds_bus), 70'd0);
    cycle();
    resetn = 1'b1;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    chk("orphan_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("orphan_ds", 70'(ms_to_ds_bus), 70'd0);
    cycle();
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    pc = pc_ctr; pc_ctr += 4;
    send(mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd15, 32'h0000_8000, pc));
    chk("orphan_buf_empty", 70'(ms_to_ds_bus[37]), 70'd1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1357_9BDF;
    sb.push_back({pc, 1'b1, 5'd15, 32'h1357_9BDF});
    cycle();
    data_sram_data_ok = 1'b0;
    cycle();

    chk("sb_drain", 70'(sb.size()), 70'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
